// File: rtl/dcache_responder_if.sv
// CPU-side MEM-stage data port plus word-wide backing-memory port of the data cache.
// Signal suffixes are relative to the cache: _i driven by the environment, _o by the cache.
interface dcache_responder_if;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_ack_i, mem_rdata_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_ack_i, mem_rdata_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines and 4-beat refill.
// Read hits return data combinationally; misses and stores freeze the pipeline via cpu_stall_o.
module dcache_responder #(
  parameter int LINES = 16,
  parameter int IDX_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dcache_responder_if.slave    bus
);
  localparam int TAG_W = 32 - IDX_W - 4;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES][4];

  logic [1:0]        off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;

  assign off = bus.cpu_addr_i[3:2];
  assign idx = bus.cpu_addr_i[IDX_W+3:4];
  assign tag = bus.cpu_addr_i[31:IDX_W+4];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    bus.cpu_rdata_o = 32'd0;
    bus.cpu_stall_o = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = 32'd0;
    bus.mem_wdata_o = 32'd0;
    case (state_q)
      IDLE: begin
        bus.cpu_stall_o = bus.cpu_req_i && (bus.cpu_we_i || !hit);
        if (bus.cpu_req_i && !bus.cpu_we_i && hit)
          bus.cpu_rdata_o = data_q[idx][off];
      end
      REFILL: begin
        bus.cpu_stall_o = bus.cpu_req_i;
        bus.mem_req_o   = 1'b1;
        bus.mem_addr_o  = {tag, idx, cnt_q, 2'b00};
      end
      WRITE: begin
        bus.cpu_stall_o = bus.cpu_req_i;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {bus.cpu_addr_i[31:2], 2'b00};
        bus.mem_wdata_o = bus.cpu_wdata_i;
      end
      default: ;  // WDONE: one unstalled cycle lets the store retire
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req_i) begin
            if (bus.cpu_we_i) begin
              state_q <= WRITE;
            end else if (!hit) begin
              cnt_q   <= 2'd0;
              state_q <= REFILL;
            end
          end
        end
        REFILL: begin
          if (bus.mem_ack_i) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              valid_q[idx] <= 1'b1;
              state_q      <= IDLE;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack_i)
            state_q <= WDONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == REFILL && bus.mem_ack_i) begin
      data_q[idx][cnt_q] <= bus.mem_rdata_i;
      if (cnt_q == 2'd3)
        tag_q[idx] <= tag;
    end
    if (!rst_i && state_q == WRITE && bus.mem_ack_i && hit)
      data_q[idx][off] <= bus.cpu_wdata_i;
  end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder for the pipeline's MEM-stage data port; sits between the EX/MEM register outputs and a slower word-wide backing memory.
- Direct-mapped, write-through, no-write-allocate cache with 4-word lines.
- Stalls the pipeline with cpu_stall_o during misses and write-throughs.
- Refills lines with a 4-beat req/ack burst from backing memory.

Parameters:
LINES, 16, number of cache lines (power of 2, >=2)
IDX_W, 4, log2(LINES)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
cpu_req_i  in  1  access valid this cycle (MemRead or MemWrite)
cpu_we_i  in  1  1 = write, 0 = read; only meaningful with cpu_req_i
cpu_addr_i  in  32  byte address; bits [1:0] ignored
cpu_wdata_i  in  32  store data
cpu_rdata_o  out  32  load data, valid when read hit and cpu_stall_o=0
cpu_stall_o  out  1  pipeline freeze; CPU holds req/we/addr/wdata stable while high
mem_req_o  out  1  backing-memory request, held until each ack
mem_we_o  out  1  backing-memory write strobe
mem_addr_o  out  32  word-aligned backing-memory address
mem_wdata_o  out  32  backing-memory write data
mem_ack_i  in  1  one beat accepted/returned this cycle
mem_rdata_i  in  32  read beat data, valid with mem_ack_i

Behaviour:
- Address split: offset=[3:2], index=[IDX_W+3:4], tag=[31:IDX_W+4].
- Storage: valid bit per line (reset to 0), tag array, 4x32 data array per line (data/tag not reset).
- FSM states: IDLE, REFILL, WRITE, WDONE.
- rst_i:
  - next state IDLE; all valid bits cleared; beat counter cleared.
  - Takes effect mid-REFILL/WRITE: the aborted line stays invalid and mem_req_o is 0 the cycle after reset.
- Outputs per state:
  - IDLE: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - cpu_rdata_o=0 except during an IDLE read hit.
  - cpu_stall_o=0 when cpu_req_i=0.
- IDLE, read, hit (valid && tag match): cpu_rdata_o=data[index][offset] combinationally, stall=0, zero latency.
- IDLE, read, miss: stall=1 same cycle; beat counter cnt=0; go REFILL.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={tag,index,cnt,2'b00}, stall=1.
  - On mem_ack_i: data[index][cnt]<=mem_rdata_i, cnt++.
  - On the ack with cnt==3: valid[index]<=1, tag[index]<=tag, go IDLE.
  - Next cycle the held request hits and stall drops.
  - Miss penalty with zero-wait memory: 5 stall cycles.
- IDLE, write (hit or miss): stall=1; go WRITE.
- WRITE:
  - mem_req_o=1, mem_we_o=1, mem_addr_o={addr[31:2],2'b00}, mem_wdata_o=cpu_wdata_i, stall=1.
  - On mem_ack_i: if hit, data[index][offset]<=cpu_wdata_i; miss leaves cache unchanged. Go WDONE.
- WDONE: stall=0 for exactly one cycle so the store retires; always go IDLE (no re-issue of the held write).
- mem_ack_i in IDLE/WDONE is ignored.
- Back-to-back acks are legal; mem_req_o stays high across refill beats.
- Read following a write to the same line sees the new data.
- A miss replaces the line unconditionally (no write-back needed).

Test Plan:
- Reset then read 0x0000_0104, mem returns 0xA0..0xA3 for addrs 0x100..0x10C with ack every cycle -> stall high 5 cycles, mem_addr_o steps 0x100,0x104,0x108,0x10C, then cpu_rdata_o=0xA1, stall=0.
- Read hit 0x0000_010C after that refill -> cpu_rdata_o=0xA3 same cycle, mem_req_o=0.
- Write 0x0000_0108 data 0xDEADBEEF, ack after 3 wait cycles -> mem_we_o=1 and mem_addr_o=0x108 held 4 cycles, one WDONE cycle with stall=0; later read 0x108 hits -> 0xDEADBEEF.
- Write miss 0x0000_2000 data 0x55 -> one write-through beat, then read 0x2000 misses and refills (no allocate on write).
- Conflict: read 0x0000_0100 then 0x0000_1100 (same index 0, tags differ) -> second access refills; re-reading 0x100 misses again.
- rst_i asserted during beat 2 of a refill -> mem_req_o=0 next cycle; re-read of same address misses and performs a full 4-beat refill.
